alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the 32-bit ALU.
- Latches decoded operands and the ALU control code, and selects the immediate or register second operand.
- Resolves MEM/WB forwarding and detects load-use hazards.
- Drives in1/in2/ctrl of the ALU and carries writeback metadata alongside.

Parameters:
- DATA_WIDTH, 32, operand width (matches config DATA_WIDTH)
- CTRL_WIDTH, 4, ALU control width (matches config CTRL_WIDTH)
- REG_AW, 5, register address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts the instruction this cycle
- id_rs_addr, id_rt_addr  in  REG_AW  source register numbers
- id_rs_val, id_rt_val  in  DATA_WIDTH  register-file read data
- id_imm  in  16  raw immediate field (shamt is in bits 10:6)
- id_use_imm  in  1  in2 comes from the immediate
- id_imm_sext  in  1  sign-extend (1) or zero-extend (0) the immediate
- id_ctrl  in  CTRL_WIDTH  ALU operation code
- id_dest  in  REG_AW  destination register
- id_wen  in  1  instruction writes a register
- id_mem_read  in  1  instruction is a load
- mem_fwd_addr  in  REG_AW  MEM stage destination
- mem_fwd_wen  in  1  MEM stage writes a register
- mem_fwd_data  in  DATA_WIDTH  MEM stage result
- wb_fwd_addr  in  REG_AW  WB stage destination
- wb_fwd_wen  in  1  WB stage writes a register
- wb_fwd_data  in  DATA_WIDTH  WB stage result
- ex_stall  in  1  downstream cannot advance
- flush  in  1  taken branch; kill the held instruction
- alu_in1, alu_in2  out  DATA_WIDTH  ALU operands
- alu_ctrl  out  CTRL_WIDTH  ALU control
- ex_valid  out  1  held instruction is live
- ex_dest  out  REG_AW  destination register of the held instruction
- ex_wen  out  1  write enable, gated by ex_valid
- ex_mem_read  out  1  load flag, gated by ex_valid

Behaviour:
- Reset (async, rst=1):
  - All held registers clear; ex_valid=0, ex_wen=0, ex_mem_read=0.
  - alu_ctrl=4'b0000; alu_in1 and alu_in2 are forced to 0 while ex_valid=0.
- Immediate extension: sext replicates id_imm[15], zext pads with zeros, giving 32 bits. The extended value is latched as the in2 candidate when id_use_imm=1.
  - Shifts (ctrl 1000/1001/1010) use the immediate path unmodified; the ALU extracts in2[10:6].
- Load-use hazard: hz = ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==id_rs_addr | (ex_dest==id_rt_addr & !id_use_imm)).
- id_ready = !ex_stall & !hz.
- Clock-edge update, in priority order:
  1. flush=1: ex_valid<=0. Takes precedence over stall and hazard; the decode instruction is not accepted.
  2. ex_stall=1: all held registers keep their values. Exception: a held rs/rt source whose address equals wb_fwd_addr (nonzero, wb_fwd_wen=1) captures wb_fwd_data, so the WB value is not lost.
  3. hz=1: insert a bubble (ex_valid<=0, wen/mem_read cleared). The decode instruction stays pending; id_ready was 0.
  4. Otherwise: load the id_* fields; ex_valid<=id_valid.
- Forwarding (combinational on held values, applied to rs and to rt when not using the immediate):
  - Select MEM if mem_fwd_wen & mem_fwd_addr==src & src!=0.
  - Else select WB if wb_fwd_wen & wb_fwd_addr==src & src!=0.
  - Else use the held value.
  - MEM beats WB when both match. Register 0 always reads 0 and is never forwarded.
- Latency: one cycle from acceptance to valid ALU inputs. The output path is combinational forwarding only.
- flush and rst mid-stall: the held instruction is dropped; no partial state survives.
- Single-cycle throughput when there is no stall or hazard.

Decomposition:
- Shared package / config include: DATA_WIDTH, CTRL_WIDTH, REG_AW, ALU opcode constants (ALU_AND … ALU_SLE, ALU_SLL=4'b1000, ALU_LUI=4'b1011).
- One sub-module, fwd_mux: combinational source selector, instantiated twice (rs, rt).

Test Plan:
- Reset then ADD: rst pulse; id rs=5 (val 7), rt=6 (val 9), ctrl 0010, no forwards.
  -> Next cycle alu_in1=7, alu_in2=9, alu_ctrl=0010, ex_valid=1.
- Immediate with sign extension: id_imm=16'hFFFE, sext=1, use_imm=1 -> alu_in2=32'hFFFFFFFE. With sext=0 -> 32'h0000FFFE.
- Forward priority: held rs=3; mem_fwd (3, 32'hAAAA) and wb_fwd (3, 32'hBBBB) both active.
  -> alu_in1=32'hAAAA. With the MEM write disabled -> 32'hBBBB. With rs=0 -> 0.
- Load-use: held LW to r4 (ex_mem_read=1); decode uses rs=4.
  -> id_ready=0 one cycle and a bubble (ex_valid=0). The next cycle accepts it, with forwarding from MEM.
- Stall with WB capture: ex_stall=1 for 3 cycles; WB writes r2=32'h1234 on cycle 1; held rt=2.
  -> After release alu_in2=32'h1234 and id_ready stays 0 during the stall.
- Flush beats stall: flush=1 and ex_stall=1 in the same cycle -> ex_valid=0, ex_wen=0 next cycle. Async rst mid-operation clears all outputs immediately.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_operand_stage_pkg
//
// Shared definitions for the ID/EX operand stage that feeds the 32-bit ALU.
//   - Default datapath widths (operand, ALU control, register address).
//   - ALU operation codes as seen on alu_ctrl.
//   - Forwarding source selector encoding used by fwd_mux.
//   - Small helpers for immediate handling and opcode classification.
// -----------------------------------------------------------------------------
package alu_operand_stage_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CTRL_WIDTH = 4;
    localparam int REG_AW     = 5;
    localparam int IMM_W      = 16;

    // Shift amount position inside the raw immediate field; the ALU pulls
    // in2[SHAMT_HI:SHAMT_LO] itself, so this stage never reformats it.
    localparam int SHAMT_LO   = 6;
    localparam int SHAMT_HI   = 10;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_NOR = 4'b0100,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_SRA = 4'b1010,
        ALU_LUI = 4'b1011,
        ALU_SLE = 4'b1100
    } alu_op_e;

    // Which value a forwarding mux hands to the ALU.
    typedef enum logic [1:0] {
        FWD_ZERO = 2'd0,   // source is r0: hard zero
        FWD_MEM  = 2'd1,   // MEM stage result
        FWD_WB   = 2'd2,   // WB stage result
        FWD_HELD = 2'd3    // value latched at decode
    } fwd_sel_e;

    // Shift ops consume the immediate path untouched (shamt in bits 10:6).
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    // Immediate extension for the default datapath width.
    function automatic logic [DATA_WIDTH-1:0] extend_imm(
        input logic [IMM_W-1:0] imm,
        input logic             sext
    );
        return {{(DATA_WIDTH-IMM_W){imm[IMM_W-1] & sext}}, imm};
    endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// -----------------------------------------------------------------------------
// alu_operand_stage_fwd_mux
//
// Combinational forwarding selector for one ALU source operand.
//   src_addr  : register number held in ID/EX for this source
//   held_val  : register-file value latched at decode
//   mem_*     : MEM stage destination / write enable / result
//   wb_*      : WB stage destination / write enable / result
//   out_val   : operand value after forwarding
//
// r0 always yields zero and is never forwarded. MEM is younger than WB, so
// it wins when both stages target the same register.
// -----------------------------------------------------------------------------
module alu_operand_stage_fwd_mux
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
) (
    input  logic [REG_AW-1:0]     src_addr,
    input  logic [DATA_WIDTH-1:0] held_val,
    input  logic [REG_AW-1:0]     mem_addr,
    input  logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [REG_AW-1:0]     wb_addr,
    input  logic                  wb_wen,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] out_val
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_HELD;
        if (src_addr == '0) begin
            sel = FWD_ZERO;
        end else if (mem_wen && (mem_addr == src_addr)) begin
            sel = FWD_MEM;
        end else if (wb_wen && (wb_addr == src_addr)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        out_val = held_val;
        case (sel)
            FWD_ZERO: out_val = '0;
            FWD_MEM:  out_val = mem_data;
            FWD_WB:   out_val = wb_data;
            default:  out_val = held_val;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// ID/EX pipeline register directly upstream of the ALU.
//
// Decode side:
//   id_valid / id_ready        handshake with decode
//   id_rs_*, id_rt_*           source register numbers and read data
//   id_imm, id_use_imm,
//   id_imm_sext                immediate field, in2 select, extension mode
//   id_ctrl                    ALU operation code
//   id_dest, id_wen,
//   id_mem_read                writeback metadata
// Forwarding side:
//   mem_fwd_*, wb_fwd_*        destination / enable / result of MEM and WB
// Control:
//   ex_stall                   downstream cannot advance
//   flush                      taken branch, drop the held instruction
// ALU side:
//   alu_in1, alu_in2, alu_ctrl operands (zero while no live instruction)
//   ex_valid, ex_dest, ex_wen,
//   ex_mem_read                metadata of the held instruction
//
// Edge priority: flush > stall > load-use bubble > normal load.
// -----------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4,
    parameter int REG_AW     = 5
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [REG_AW-1:0]     id_rs_addr,
    input  logic [REG_AW-1:0]     id_rt_addr,
    input  logic [DATA_WIDTH-1:0] id_rs_val,
    input  logic [DATA_WIDTH-1:0] id_rt_val,
    input  logic [15:0]           id_imm,
    input  logic                  id_use_imm,
    input  logic                  id_imm_sext,
    input  logic [CTRL_WIDTH-1:0] id_ctrl,
    input  logic [REG_AW-1:0]     id_dest,
    input  logic                  id_wen,
    input  logic                  id_mem_read,

    input  logic [REG_AW-1:0]     mem_fwd_addr,
    input  logic                  mem_fwd_wen,
    input  logic [DATA_WIDTH-1:0] mem_fwd_data,
    input  logic [REG_AW-1:0]     wb_fwd_addr,
    input  logic                  wb_fwd_wen,
    input  logic [DATA_WIDTH-1:0] wb_fwd_data,

    input  logic                  ex_stall,
    input  logic                  flush,

    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    output logic [CTRL_WIDTH-1:0] alu_ctrl,
    output logic                  ex_valid,
    output logic [REG_AW-1:0]     ex_dest,
    output logic                  ex_wen,
    output logic                  ex_mem_read
);

    import alu_operand_stage_pkg::*;

    localparam int NSRC = 2;   // index 0 = rs, index 1 = rt

    // ------------------------------------------------------------------
    // Held ID/EX state
    // ------------------------------------------------------------------
    logic                  valid_reg;
    logic [REG_AW-1:0]     src_addr_reg [NSRC];
    logic [DATA_WIDTH-1:0] src_val_reg  [NSRC];
    logic                  use_imm_reg;
    logic [DATA_WIDTH-1:0] imm_ext_reg;
    logic [CTRL_WIDTH-1:0] ctrl_reg;
    logic [REG_AW-1:0]     dest_reg;
    logic                  wen_reg;
    logic                  mem_read_reg;

    // Decode-side views indexed the same way as the held sources.
    logic [REG_AW-1:0]     id_src_addr [NSRC];
    logic [DATA_WIDTH-1:0] id_src_val  [NSRC];
    logic [DATA_WIDTH-1:0] fwd_val     [NSRC];

    logic [DATA_WIDTH-1:0] imm_ext_next;
    logic                  hz;
    logic                  wb_capture;

    assign id_src_addr[0] = id_rs_addr;
    assign id_src_addr[1] = id_rt_addr;
    assign id_src_val[0]  = id_rs_val;
    assign id_src_val[1]  = id_rt_val;

    // Shift ops need no special case: the raw field goes through and the
    // ALU picks out the shamt bits itself.
    assign imm_ext_next = {{(DATA_WIDTH-16){id_imm[15] & id_imm_sext}}, id_imm};

    // Load-use hazard: the held load's data is not yet available to forward.
    // rt only matters when in2 actually comes from the register.
    assign hz = valid_reg && mem_read_reg && (dest_reg != '0) &&
                ((dest_reg == id_rs_addr) ||
                 ((dest_reg == id_rt_addr) && !id_use_imm));

    assign id_ready = !ex_stall && !hz;

    // While stalled, WB retires and leaves the forwarding window; snapshot its
    // value into any held source it targets so the stall does not lose it.
    assign wb_capture = wb_fwd_wen && (wb_fwd_addr != '0);

    // ------------------------------------------------------------------
    // Control / metadata registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg    <= 1'b0;
            use_imm_reg  <= 1'b0;
            imm_ext_reg  <= '0;
            ctrl_reg     <= CTRL_WIDTH'(ALU_AND);
            dest_reg     <= '0;
            wen_reg      <= 1'b0;
            mem_read_reg <= 1'b0;
        end else if (flush) begin
            valid_reg    <= 1'b0;
            wen_reg      <= 1'b0;
            mem_read_reg <= 1'b0;
        end else if (ex_stall) begin
            // hold everything
        end else if (hz) begin
            // bubble; decode instruction remains pending upstream
            valid_reg    <= 1'b0;
            wen_reg      <= 1'b0;
            mem_read_reg <= 1'b0;
        end else begin
            valid_reg    <= id_valid;
            use_imm_reg  <= id_use_imm;
            imm_ext_reg  <= imm_ext_next;
            ctrl_reg     <= id_ctrl;
            dest_reg     <= id_dest;
            wen_reg      <= id_wen;
            mem_read_reg <= id_mem_read;
        end
    end

    // ------------------------------------------------------------------
    // Source operand registers and forwarding, one lane per source
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    src_addr_reg[gi] <= '0;
                    src_val_reg[gi]  <= '0;
                end else if (flush) begin
                    // dropped instruction: operand contents are don't-care
                end else if (ex_stall) begin
                    if (wb_capture && (src_addr_reg[gi] == wb_fwd_addr)) begin
                        src_val_reg[gi] <= wb_fwd_data;
                    end
                end else if (!hz) begin
                    src_addr_reg[gi] <= id_src_addr[gi];
                    src_val_reg[gi]  <= id_src_val[gi];
                end
            end

            alu_operand_stage_fwd_mux #(
                .DATA_WIDTH (DATA_WIDTH),
                .REG_AW     (REG_AW)
            ) u_fwd_mux (
                .src_addr (src_addr_reg[gi]),
                .held_val (src_val_reg[gi]),
                .mem_addr (mem_fwd_addr),
                .mem_wen  (mem_fwd_wen),
                .mem_data (mem_fwd_data),
                .wb_addr  (wb_fwd_addr),
                .wb_wen   (wb_fwd_wen),
                .wb_data  (wb_fwd_data),
                .out_val  (fwd_val[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // ALU-facing outputs; operands read as zero when nothing is live
    // ------------------------------------------------------------------
    always_comb begin
        alu_in1 = '0;
        alu_in2 = '0;
        if (valid_reg) begin
            alu_in1 = fwd_val[0];
            alu_in2 = use_imm_reg ? imm_ext_reg : fwd_val[1];
        end
    end

    assign alu_ctrl    = ctrl_reg;
    assign ex_valid    = valid_reg;
    assign ex_dest     = dest_reg;
    assign ex_wen      = valid_reg & wen_reg;
    assign ex_mem_read = valid_reg & mem_read_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Directed scenarios followed by a randomized run against a behavioural
// model of the ID/EX slot (one held instruction, forwarding by rule).
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs_addr, id_rt_addr;
    logic [31:0] id_rs_val, id_rt_val;
    logic [15:0] id_imm;
    logic        id_use_imm, id_imm_sext;
    logic [3:0]  id_ctrl;
    logic [4:0]  id_dest;
    logic        id_wen, id_mem_read;
    logic [4:0]  mem_fwd_addr, wb_fwd_addr;
    logic        mem_fwd_wen, wb_fwd_wen;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        ex_stall, flush;
    logic [31:0] alu_in1, alu_in2;
    logic [3:0]  alu_ctrl;
    logic        ex_valid;
    logic [4:0]  ex_dest;
    logic        ex_wen, ex_mem_read;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_imm_sext(id_imm_sext),
        .id_ctrl(id_ctrl), .id_dest(id_dest), .id_wen(id_wen),
        .id_mem_read(id_mem_read),
        .mem_fwd_addr(mem_fwd_addr), .mem_fwd_wen(mem_fwd_wen),
        .mem_fwd_data(mem_fwd_data),
        .wb_fwd_addr(wb_fwd_addr), .wb_fwd_wen(wb_fwd_wen),
        .wb_fwd_data(wb_fwd_data),
        .ex_stall(ex_stall), .flush(flush),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
        .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_wen(ex_wen),
        .ex_mem_read(ex_mem_read)
    );

    // ---------------- behavioural model: the single held instruction -------
    logic        m_valid;
    logic [4:0]  m_rs, m_rt, m_dest;
    logic [31:0] m_rsv, m_rtv, m_imm;
    logic        m_useimm, m_wen, m_load;
    logic [3:0]  m_ctrl;

    task automatic model_reset();
        m_valid = 0; m_rs = 0; m_rt = 0; m_dest = 0; m_rsv = 0; m_rtv = 0;
        m_imm = 0; m_useimm = 0; m_wen = 0; m_load = 0; m_ctrl = 0;
    endtask

    // Value the ALU should see for a register read: r0 is zero, the youngest
    // in-flight writer wins, otherwise whatever was read at decode.
    function automatic logic [31:0] ref_read(input logic [4:0] r, input logic [31:0] held);
        if (r == 0) return 32'd0;
        if (mem_fwd_wen && mem_fwd_addr == r) return mem_fwd_data;
        if (wb_fwd_wen && wb_fwd_addr == r) return wb_fwd_data;
        return held;
    endfunction

    function automatic logic ref_hazard();
        if (!m_valid || !m_load || m_dest == 0) return 1'b0;
        if (m_dest == id_rs_addr) return 1'b1;
        if (!id_use_imm && m_dest == id_rt_addr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_imm();
        logic [31:0] v;
        v = 32'(id_imm);
        if (id_imm_sext && id_imm >= 16'h8000) v = v - 32'h0001_0000;
        return v;
    endfunction

    // Advance one clock; the model applies the same edge using the inputs
    // that were present before it.
    task automatic tick();
        logic hz;
        @(posedge clk);
        hz = ref_hazard();
        if (flush) begin
            m_valid = 0; m_wen = 0; m_load = 0;
        end else if (ex_stall) begin
            if (wb_fwd_wen && wb_fwd_addr != 0) begin
                if (m_rs == wb_fwd_addr) m_rsv = wb_fwd_data;
                if (m_rt == wb_fwd_addr) m_rtv = wb_fwd_data;
            end
        end else if (hz) begin
            m_valid = 0; m_wen = 0; m_load = 0;
        end else begin
            m_valid = id_valid; m_rs = id_rs_addr; m_rt = id_rt_addr;
            m_rsv = id_rs_val; m_rtv = id_rt_val; m_useimm = id_use_imm;
            m_imm = ref_imm(); m_ctrl = id_ctrl; m_dest = id_dest;
            m_wen = id_wen; m_load = id_mem_read;
        end
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_val = 0; id_rt_val = 0;
        id_imm = 0; id_use_imm = 0; id_imm_sext = 0; id_ctrl = 0; id_dest = 0;
        id_wen = 0; id_mem_read = 0;
        mem_fwd_addr = 0; mem_fwd_wen = 0; mem_fwd_data = 0;
        wb_fwd_addr = 0; wb_fwd_wen = 0; wb_fwd_data = 0;
        ex_stall = 0; flush = 0;
    endtask

    // ---------------- directed scenarios ----------------------------------
    task automatic test_reset();
        rst = 1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid: got %b want 0", ex_valid); else pass_cnt++;
        total_cnt++; if (ex_wen !== 1'b0 || ex_mem_read !== 1'b0) $display("FAIL reset_wen_mr: got %b%b want 00", ex_wen, ex_mem_read); else pass_cnt++;
        total_cnt++; if (alu_ctrl !== 4'b0000) $display("FAIL reset_ctrl: got %b want 0000", alu_ctrl); else pass_cnt++;
        total_cnt++; if (alu_in1 !== 0 || alu_in2 !== 0) $display("FAIL reset_operands: got %h/%h want 0/0", alu_in1, alu_in2); else pass_cnt++;
        rst = 0;
        $display("reset: ex_valid=%b alu_ctrl=%b", ex_valid, alu_ctrl);
    endtask

    task automatic test_add();
        id_valid = 1; id_rs_addr = 5; id_rs_val = 7; id_rt_addr = 6; id_rt_val = 9;
        id_ctrl = 4'b0010; id_dest = 8; id_wen = 1;
        tick();
        total_cnt++; if (alu_in1 !== 32'd7) $display("FAIL add_in1: got %h want 7", alu_in1); else pass_cnt++;
        total_cnt++; if (alu_in2 !== 32'd9) $display("FAIL add_in2: got %h want 9", alu_in2); else pass_cnt++;
        total_cnt++; if (alu_ctrl !== 4'b0010) $display("FAIL add_ctrl: got %b want 0010", alu_ctrl); else pass_cnt++;
        total_cnt++; if (ex_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", ex_valid); else pass_cnt++;
        $display("add: in1=%h in2=%h ctrl=%b", alu_in1, alu_in2, alu_ctrl);
        clear_inputs();
    endtask

    task automatic test_immediate();
        id_valid = 1; id_rs_addr = 1; id_use_imm = 1; id_imm_sext = 1; id_imm = 16'hFFFE;
        id_ctrl = 4'b0010; id_dest = 2; id_wen = 1;
        tick();
        total_cnt++; if (alu_in2 !== 32'hFFFF_FFFE) $display("FAIL imm_sext: got %h want fffffffe", alu_in2); else pass_cnt++;
        $display("imm sext: in2=%h", alu_in2);
        id_imm_sext = 0;
        tick();
        total_cnt++; if (alu_in2 !== 32'h0000_FFFE) $display("FAIL imm_zext: got %h want 0000fffe", alu_in2); else pass_cnt++;
        $display("imm zext: in2=%h", alu_in2);
        // shift: immediate passes through unmodified
        id_ctrl = 4'b1000; id_imm = 16'h0140; id_imm_sext = 1;
        tick();
        total_cnt++; if (alu_in2 !== 32'h0000_0140 || alu_ctrl !== 4'b1000) $display("FAIL imm_shift: got %h/%b want 00000140/1000", alu_in2, alu_ctrl); else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_fwd_priority();
        id_valid = 1; id_rs_addr = 3; id_rs_val = 1; id_ctrl = 4'b0010;
        tick();
        id_valid = 0;
        mem_fwd_addr = 3; mem_fwd_wen = 1; mem_fwd_data = 32'hAAAA;
        wb_fwd_addr = 3; wb_fwd_wen = 1; wb_fwd_data = 32'hBBBB;
        #1;
        total_cnt++; if (alu_in1 !== 32'hAAAA) $display("FAIL fwd_mem_first: got %h want aaaa", alu_in1); else pass_cnt++;
        mem_fwd_wen = 0;
        #1;
        total_cnt++; if (alu_in1 !== 32'hBBBB) $display("FAIL fwd_wb: got %h want bbbb", alu_in1); else pass_cnt++;
        wb_fwd_wen = 0;
        #1;
        total_cnt++; if (alu_in1 !== 32'd1) $display("FAIL fwd_none: got %h want 1", alu_in1); else pass_cnt++;
        id_valid = 1; id_rs_addr = 0; id_rs_val = 32'h55;
        tick();
        mem_fwd_addr = 0; mem_fwd_wen = 1; wb_fwd_addr = 0; wb_fwd_wen = 1;
        #1;
        total_cnt++; if (alu_in1 !== 32'd0) $display("FAIL fwd_r0: got %h want 0", alu_in1); else pass_cnt++;
        $display("fwd priority: r0 operand=%h", alu_in1);
        clear_inputs();
    endtask

    task automatic test_load_use();
        id_valid = 1; id_rs_addr = 1; id_rt_addr = 1; id_dest = 4; id_wen = 1;
        id_mem_read = 1; id_ctrl = 4'b0010; id_use_imm = 1;
        tick();
        total_cnt++; if (ex_mem_read !== 1'b1) $display("FAIL lu_load_held: got %b want 1", ex_mem_read); else pass_cnt++;
        id_rs_addr = 4; id_rt_addr = 5; id_use_imm = 0; id_mem_read = 0; id_dest = 6;
        #1;
        total_cnt++; if (id_ready !== 1'b0) $display("FAIL lu_ready_low: got %b want 0", id_ready); else pass_cnt++;
        tick();
        total_cnt++; if (ex_valid !== 1'b0 || ex_wen !== 1'b0) $display("FAIL lu_bubble: got %b%b want 00", ex_valid, ex_wen); else pass_cnt++;
        mem_fwd_addr = 4; mem_fwd_wen = 1; mem_fwd_data = 32'hCAFE;
        #1;
        total_cnt++; if (id_ready !== 1'b1) $display("FAIL lu_ready_back: got %b want 1", id_ready); else pass_cnt++;
        tick();
        total_cnt++; if (ex_valid !== 1'b1 || alu_in1 !== 32'hCAFE) $display("FAIL lu_accept_fwd: got %b/%h want 1/cafe", ex_valid, alu_in1); else pass_cnt++;
        $display("load-use: accepted in1=%h", alu_in1);
        clear_inputs();
    endtask

    task automatic test_stall_wb();
        id_valid = 1; id_rs_addr = 1; id_rt_addr = 2; id_rt_val = 32'h1; id_dest = 7; id_wen = 1;
        tick();
        ex_stall = 1; id_rt_val = 32'h9999; id_rs_addr = 9;
        wb_fwd_addr = 2; wb_fwd_wen = 1; wb_fwd_data = 32'h1234;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++; if (id_ready !== 1'b0) $display("FAIL stall_ready_c%0d: got %b want 0", c, id_ready); else pass_cnt++;
            tick();
            wb_fwd_wen = 0; wb_fwd_data = 32'h0;
        end
        ex_stall = 0;
        #1;
        total_cnt++; if (alu_in2 !== 32'h1234) $display("FAIL stall_wb_capture: got %h want 1234", alu_in2); else pass_cnt++;
        total_cnt++; if (ex_dest !== 5'd7) $display("FAIL stall_dest_held: got %0d want 7", ex_dest); else pass_cnt++;
        $display("stall: in2 after release=%h", alu_in2);
        clear_inputs();
    endtask

    task automatic test_flush();
        id_valid = 1; id_rs_addr = 1; id_dest = 3; id_wen = 1;
        tick();
        total_cnt++; if (ex_wen !== 1'b1) $display("FAIL flush_pre_wen: got %b want 1", ex_wen); else pass_cnt++;
        flush = 1; ex_stall = 1;
        tick();
        total_cnt++; if (ex_valid !== 1'b0 || ex_wen !== 1'b0) $display("FAIL flush_over_stall: got %b%b want 00", ex_valid, ex_wen); else pass_cnt++;
        $display("flush: ex_valid=%b ex_wen=%b", ex_valid, ex_wen);
        clear_inputs();
    endtask

    task automatic test_async_reset();
        id_valid = 1; id_rs_addr = 2; id_rs_val = 32'h77; id_ctrl = 4'b0110; id_wen = 1;
        id_dest = 5; id_mem_read = 1;
        tick();
        #2;
        rst = 1;
        #1;
        model_reset();
        total_cnt++; if (ex_valid !== 1'b0 || ex_wen !== 1'b0 || ex_mem_read !== 1'b0) $display("FAIL arst_flags: got %b%b%b want 000", ex_valid, ex_wen, ex_mem_read); else pass_cnt++;
        total_cnt++; if (alu_in1 !== 0 || alu_ctrl !== 4'b0000) $display("FAIL arst_outputs: got %h/%b want 0/0000", alu_in1, alu_ctrl); else pass_cnt++;
        $display("async reset: ex_valid=%b", ex_valid);
        clear_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    // ---------------- randomized run against the model --------------------
    task automatic test_random();
        int accepted = 0;
        for (int i = 0; i < 400; i++) begin
            id_valid     = ($urandom_range(3) != 0);
            id_rs_addr   = 5'($urandom_range(7));
            id_rt_addr   = 5'($urandom_range(7));
            id_rs_val    = $urandom;
            id_rt_val    = $urandom;
            id_imm       = 16'($urandom);
            id_use_imm   = 1'($urandom_range(1));
            id_imm_sext  = 1'($urandom_range(1));
            id_ctrl      = 4'($urandom_range(12));
            id_dest      = 5'($urandom_range(7));
            id_wen       = 1'($urandom_range(1));
            id_mem_read  = ($urandom_range(2) == 0);
            mem_fwd_addr = 5'($urandom_range(7));
            mem_fwd_wen  = 1'($urandom_range(1));
            mem_fwd_data = $urandom;
            wb_fwd_addr  = 5'($urandom_range(7));
            wb_fwd_wen   = 1'($urandom_range(1));
            wb_fwd_data  = $urandom;
            ex_stall     = ($urandom_range(4) == 0);
            flush        = ($urandom_range(15) == 0);
            #1;
            total_cnt++;
            if (id_ready !== (!ex_stall && !ref_hazard()))
                $display("FAIL rnd_ready[%0d]: got %b want %b", i, id_ready, !ex_stall && !ref_hazard());
            else pass_cnt++;
            total_cnt++;
            if (ex_valid !== m_valid || ex_wen !== (m_valid & m_wen) ||
                ex_mem_read !== (m_valid & m_load) || alu_ctrl !== m_ctrl ||
                ex_dest !== m_dest)
                $display("FAIL rnd_meta[%0d]: got v%b w%b l%b c%h d%0d want v%b w%b l%b c%h d%0d",
                         i, ex_valid, ex_wen, ex_mem_read, alu_ctrl, ex_dest,
                         m_valid, m_valid & m_wen, m_valid & m_load, m_ctrl, m_dest);
            else pass_cnt++;
            total_cnt++;
            if (alu_in1 !== (m_valid ? ref_read(m_rs, m_rsv) : 32'd0))
                $display("FAIL rnd_in1[%0d]: got %h want %h", i, alu_in1, m_valid ? ref_read(m_rs, m_rsv) : 32'd0);
            else pass_cnt++;
            total_cnt++;
            if (alu_in2 !== (!m_valid ? 32'd0 : (m_useimm ? m_imm : ref_read(m_rt, m_rtv))))
                $display("FAIL rnd_in2[%0d]: got %h want %h", i, alu_in2,
                         !m_valid ? 32'd0 : (m_useimm ? m_imm : ref_read(m_rt, m_rtv)));
            else pass_cnt++;
            if (id_valid && id_ready && !flush) begin
                accepted++;
                $display("rnd %0d: accept rs=%0d rt=%0d ctrl=%h dest=%0d", i, id_rs_addr, id_rt_addr, id_ctrl, id_dest);
            end
            tick();
        end
        $display("random: %0d instructions accepted", accepted);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_add();
        test_immediate();
        test_fwd_priority();
        test_load_use();
        test_stall_wb();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
